// File: rtl/fifo_param_pkg.sv
// fifo_param_pkg
//   Shared helpers for the parametrised FIFO:
//   - cw(depth):        width of an occupancy counter that can hold 0..depth
//   - pw(depth):        width of a pointer that indexes 0..depth-1
//   - params_ok(...):   legality of the depth / threshold combination
package fifo_param_pkg;

    function automatic int cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A one-entry pointer still needs one bit so the port is never zero-width.
    function automatic int pw(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic bit params_ok(input int depth, input int af_lvl, input int ae_lvl);
        return (depth >= 2) && (af_lvl >= 0) && (af_lvl <= depth) &&
               (ae_lvl >= 0) && (ae_lvl < depth);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr
//   Storage pointer that counts 0..DEPTH-1 and wraps back to 0. DEPTH need not
//   be a power of two, so the wrap is an explicit compare rather than rollover.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (ptr -> 0)
//   clr    synchronous return to 0, takes priority over inc
//   inc    advance by one entry
//   ptr    current pointer value
module fifo_wrap_ptr
    import fifo_param_pkg::*;
#(
    parameter int DEPTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   inc,
    output logic [pw(DEPTH)-1:0]   ptr
);

    localparam int PW = pw(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

endmodule

// File: rtl/fifo_param.sv
// fifo_param
//   Parametrised single-clock FIFO with occupancy count, almost-full/empty
//   thresholds, sticky overflow/underflow flags and a synchronous flush.
//
// Handshake: wr/rd are requests, not valid/ready pairs. A write is taken when
//   wr is high and the FIFO is not full, or when it is full but a read is
//   taken in the same cycle. A read is taken when rd is high and the FIFO is
//   not empty; its data appears on dout one clock later, qualified by a
//   one-cycle rd_valid pulse. Requests that cannot be taken are dropped and
//   recorded in the sticky overflow/underflow flags.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          synchronous empty; overrides wr/rd, leaves dout and flags
//   wr, din        write request and data
//   rd             read request
//   dout, rd_valid registered read data and its one-cycle update pulse
//   count          current occupancy
//   empty, full    count==0, count==DEPTH
//   almost_full    count>=AF_LVL
//   almost_empty   count<=AE_LVL
//   clr_err        clears overflow/underflow (a same-cycle new event wins)
//   overflow       sticky: a write was dropped
//   underflow      sticky: a read was dropped
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 10,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr,
    input  logic [WIDTH-1:0]       din,
    input  logic                   rd,
    output logic [WIDTH-1:0]       dout,
    output logic                   rd_valid,
    output logic [cw(DEPTH)-1:0]   count,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic                   almost_empty,
    input  logic                   clr_err,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int CW = cw(DEPTH);
    localparam int PW = pw(DEPTH);

    if (!params_ok(DEPTH, AF_LVL, AE_LVL)) begin : g_bad_params
        $error("fifo_param: illegal DEPTH/AF_LVL/AE_LVL combination");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic             wa;
    logic             ra;
    logic             ovf_evt;
    logic             unf_evt;

    // Flags decode only the registered count.
    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_full  = (count >= CW'(AF_LVL));
    assign almost_empty = (count <= CW'(AE_LVL));

    // When full, empty is necessarily low, so wr & rd at full is always a
    // matched pop+push. When empty, a same-cycle read is refused: no fall-through.
    assign ra      = !flush && rd && !empty;
    assign wa      = !flush && wr && (!full || rd);
    assign ovf_evt = !flush && wr && full && !rd;
    assign unf_evt = !flush && rd && empty;

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (wa),
        .ptr   (wptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (ra),
        .ptr   (rptr)
    );

    // Storage carries no reset.
    always_ff @(posedge clk) begin
        if (wa) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (wa && !ra) begin
            count <= count + CW'(1);
        end else if (ra && !wa) begin
            count <= count - CW'(1);
        end
    end

    // dout keeps its last value through flush and idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= ra;
            if (ra) begin
                dout <= mem[rptr];
            end
        end
    end

    // A new event in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt || (overflow  && !clr_err);
            underflow <= unf_evt || (underflow && !clr_err);
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param
//   Directed scenarios followed by a randomized phase, all compared each cycle
//   against a queue-based reference model of the FIFO.
module tb_fifo_param;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 10;
    localparam int AF_LVL = DEPTH - 2;
    localparam int AE_LVL = 2;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             wr;
    logic [WIDTH-1:0] din;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             rd_valid;
    logic [3:0]       count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic             clr_err;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_rdv;
    logic             m_ovf;
    logic             m_unf;

    fifo_param #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .AF_LVL (AF_LVL),
        .AE_LVL (AE_LVL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr           (wr),
        .din          (din),
        .rd           (rd),
        .dout         (dout),
        .rd_valid     (rd_valid),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_dout = '0;
        m_rdv  = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    // One clock of FIFO behaviour expressed as queue operations.
    task automatic model_step(input logic w, input logic [WIDTH-1:0] d, input logic r,
                              input logic f, input logic c);
        int  n;
        logic oe;
        logic ue;
        n  = exp_q.size();
        oe = 1'b0;
        ue = 1'b0;
        m_rdv = 1'b0;
        if (f) begin
            exp_q.delete();
        end else begin
            ue = r && (n == 0);
            oe = w && (n == DEPTH) && !r;
            if (r && n > 0) begin
                m_dout = exp_q.pop_front();
                m_rdv  = 1'b1;
            end
            if (w && (n < DEPTH || r)) exp_q.push_back(d);
        end
        m_ovf = oe || (m_ovf && !c);
        m_unf = ue || (m_unf && !c);
    endtask

    task automatic compare_all(input string pfx);
        int n;
        n = exp_q.size();
        check_val({pfx, "_count"}, 32'(count), 32'(n));
        check_val({pfx, "_empty"}, 32'(empty), 32'(n == 0));
        check_val({pfx, "_full"},  32'(full),  32'(n == DEPTH));
        check_val({pfx, "_afull"}, 32'(almost_full),  32'(n >= AF_LVL));
        check_val({pfx, "_aempty"}, 32'(almost_empty), 32'(n <= AE_LVL));
        check_val({pfx, "_rdv"},   32'(rd_valid), 32'(m_rdv));
        check_val({pfx, "_dout"},  32'(dout), 32'(m_dout));
        check_val({pfx, "_ovf"},   32'(overflow), 32'(m_ovf));
        check_val({pfx, "_unf"},   32'(underflow), 32'(m_unf));
    endtask

    // ---------------- driver ----------------
    task automatic drive(input string pfx, input logic w, input logic [WIDTH-1:0] d,
                         input logic r, input logic f, input logic c);
        @(negedge clk);
        wr = w; din = d; rd = r; flush = f; clr_err = c;
        model_step(w, d, r, f, c);
        @(posedge clk);
        #1;
        compare_all(pfx);
    endtask

    task automatic idle(input string pfx);
        drive(pfx, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] pat;
        rst_n = 1'b0; flush = 1'b0; wr = 1'b0; din = '0; rd = 1'b0; clr_err = 1'b0;
        model_reset();
        #12;
        compare_all("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: fill to full, then an overflowing write
        for (int i = 1; i <= DEPTH; i++) drive("t1_wr", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        check_val("t1_full", 32'(full), 32'd1);
        drive("t1_ovf", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        check_val("t1_ovf_flag", 32'(overflow), 32'd1);
        check_val("t1_cnt_hold", 32'(count), 32'd10);

        // 2: drain, then an underflowing read
        for (int i = 1; i <= DEPTH; i++) drive("t2_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_val("t2_last", 32'(dout), 32'h0A);
        drive("t2_unf", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_val("t2_unf_flag", 32'(underflow), 32'd1);
        check_val("t2_dout_hold", 32'(dout), 32'h0A);
        drive("t2_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // 3: steady rd+wr at 7 entries, then at full
        pat = 8'h20;
        for (int i = 0; i < 7; i++) begin drive("t3_fill", 1'b1, pat, 1'b0, 1'b0, 1'b0); pat++; end
        for (int i = 0; i < 20; i++) begin drive("t3_rw7", 1'b1, pat, 1'b1, 1'b0, 1'b0); pat++; end
        check_val("t3_cnt7", 32'(count), 32'd7);
        for (int i = 0; i < 3; i++) begin drive("t3_top", 1'b1, pat, 1'b0, 1'b0, 1'b0); pat++; end
        for (int i = 0; i < 20; i++) begin drive("t3_rw10", 1'b1, pat, 1'b1, 1'b0, 1'b0); pat++; end
        check_val("t3_no_ovf", 32'(overflow), 32'd0);

        // 4: rd+wr on empty
        for (int i = 0; i < DEPTH; i++) drive("t4_drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive("t4_rw", 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        check_val("t4_cnt", 32'(count), 32'd1);
        check_val("t4_unf", 32'(underflow), 32'd1);
        check_val("t4_rdv", 32'(rd_valid), 32'd0);

        // 5: flush at count 5 with wr and rd high
        for (int i = 0; i < 4; i++) drive("t5_fill", 1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
        drive("t5_flush", 1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        check_val("t5_empty", 32'(empty), 32'd1);
        drive("t5_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_val("t5_unf_clr", 32'(underflow), 32'd0);

        // 6: asynchronous reset mid-burst at count 6
        for (int i = 0; i < 6; i++) drive("t6_fill", 1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
        drive("t6_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        drive("t6_wr", 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
        wr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        drive("t6_wr5a", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        drive("t6_rd5a", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_val("t6_dout5a", 32'(dout), 32'h5A);

        // Randomized mix
        for (int i = 0; i < 400; i++) begin
            drive("rnd", 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 15) == 0));
        end
        idle("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
